led_matrix_scan_driver: RTL and testbench
=========================================

Name: led_matrix_scan_driver

Overview:
- Downstream stage of the falling-box game core: consumes its pixel coordinate stream (3-bit column x, 4-bit row y) and drives a 16-row x 8-column LED matrix.
- Holds a 16x8 framebuffer and time-multiplexes rows with a blanking gap between rows to suppress ghosting.
- Emits a frame-start pulse so the game core can synchronise its updates.

Parameters:
- ROWS, 16, number of matrix rows; fixed to 16 in this revision.
- COLS, 8, number of matrix columns; fixed to 8 in this revision.
- SCAN_DIV, 10000, CLK cycles per row slot. Legal range: SCAN_DIV >= BLANK_CYC + 2.
- BLANK_CYC, 16, cycles at the start of each row slot with all drive off.

Ports:
- CLK  in  1  system clock
- RSTn  in  1  reset, asynchronous, active-low
- pix_valid  in  1  pixel write strobe, single-cycle qualifier
- pix_x  in  3  column of the write (0..7)
- pix_y  in  4  row of the write (0..15)
- pix_on  in  1  value written: 1 = lit
- frame_clr  in  1  clear the entire framebuffer
- row_sel  out  16  one-hot row drive, active-high; bit n = row n
- col_data  out  8  column drive, active-high; bit n = column n
- frame_start  out  1  one-cycle pulse at the start of the row 0 slot

Behaviour:
- Reset (async, RSTn=0):
  - framebuffer all 0, row index 0, slot counter 0, state BLANK, latched row 0.
  - row_sel=0, col_data=0, frame_start=0.
- Framebuffer write:
  - pix_valid=1 sets fb[pix_y][pix_x] <= pix_on on that clock edge.
  - The write is visible in fb on the next cycle.
- Clear:
  - frame_clr=1 zeroes all 128 bits on that edge.
  - If pix_valid=1 in the same cycle, frame_clr wins and the write is dropped.
- Slot counter: cnt counts 0..SCAN_DIV-1, then wraps to 0. On wrap, the row index increments modulo 16 (15 -> 0).
- State machine (two states):
  - BLANK, for cnt 0..BLANK_CYC-1: registered row_sel=0, col_data=0.
  - On the last BLANK cycle (cnt=BLANK_CYC-1), the latched row <= fb[row index].
  - DRIVE, for cnt BLANK_CYC..SCAN_DIV-1: row_sel = one-hot(row index), col_data = latched row.
  - DRIVE -> BLANK when cnt wraps.
- Output timing:
  - Outputs are registered: values reflect state/cnt with 1 cycle of latency.
  - row_sel never has more than one bit set.
  - row_sel and col_data are both 0 throughout every BLANK window.
- Writes during DRIVE of the same row do not change col_data until that row's next slot; the row latch is taken only at end of BLANK.
- frame_start:
  - High for exactly one cycle when cnt=0 and row index=0, aligned with the registered outputs of that cycle.
  - Also fires for the first slot after reset release.
  - Period is 16*SCAN_DIV cycles.
- Reset mid-scan aborts immediately: outputs go to 0 asynchronously and scanning restarts at row 0, BLANK.

Optional Feature:
- Macro: BRIGHTNESS_PWM_EN.
- When defined:
  - Adds input port brightness, width 4, after frame_clr.
  - A 4-bit free-running PWM counter increments every cycle in DRIVE and resets to 0 entering DRIVE.
  - col_data = latched row only when pwm_cnt < brightness, else 0.
  - brightness=0 gives a dark display; brightness=15 gives 15/16 duty.
  - row_sel is unaffected.
- When undefined: no brightness port; col_data is at full duty during DRIVE.

Test Plan (SCAN_DIV=20, BLANK_CYC=4 unless noted):
- Reset check: hold RSTn=0 for 5 cycles, release -> row_sel=0 and col_data=0 for the first 4 cycles (+1 latency); frame_start pulses once in the first cycle after release; row_sel=16'h0001 from the 5th registered cycle.
- Pixel write: write (x=3, y=2, on=1) -> in the row 2 slot, row_sel=16'h0004 and col_data=8'h08 during DRIVE; all other rows show col_data=0.
- Clear priority: assert frame_clr and pix_valid (x=0, y=0, on=1) in the same cycle -> the row 0 slot shows col_data=8'h00.
- Mid-row write: during DRIVE of row 5 with col_data=8'h00, write (x=7, y=5) -> col_data stays 8'h00 for the rest of the slot; next row 5 slot shows 8'h80.
- Frame timing: count cycles between frame_start pulses -> exactly 320; row_sel sequence 0x0001..0x8000 then 0x0001; BLANK gap of 4 cycles of all-zero drive between every pair of rows.
- Reset mid-scan: assert RSTn=0 during the row 9 DRIVE phase -> row_sel=0 and col_data=0 asynchronously; after release, scanning restarts at row 0 with framebuffer cleared.
- With BRIGHTNESS_PWM_EN, brightness=4: col_data is active for 4 of every 16 DRIVE cycles.

Source files
------------

// File: rtl/led_matrix_scan_driver.sv
// Row-multiplexed driver for a 16x8 LED matrix with a blanking gap per row slot.
// Optional macro BRIGHTNESS_PWM_EN adds a 4-bit brightness input gating col_data.
module led_matrix_scan_driver #(
  parameter int ROWS      = 16,
  parameter int COLS      = 8,
  parameter int SCAN_DIV  = 10000,
  parameter int BLANK_CYC = 16
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            pix_valid,
  input  logic [2:0]      pix_x,
  input  logic [3:0]      pix_y,
  input  logic            pix_on,
  input  logic            frame_clr,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]      brightness,
`endif
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic            frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [ROWS-1:0]  ROW_ONE    = ROWS'(1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  logic [ROWS-1:0][COLS-1:0] fb_q, fb_d;
  logic [3:0]                row_idx_q, row_idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  state_t                    state_q, state_d;
  logic [COLS-1:0]           latch_q, latch_d;
  logic [ROWS-1:0]           row_sel_q, row_sel_d;
  logic [COLS-1:0]           col_data_q, col_data_d;
  logic                      frame_start_q, frame_start_d;
  logic                      cnt_wrap;
  logic                      col_en;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]                pwm_cnt_q, pwm_cnt_d;
`endif

  always_comb begin
    // Clear dominates a coincident pixel write.
    fb_d = fb_q;
    if (frame_clr) begin
      fb_d = '0;
    end else if (pix_valid) begin
      fb_d[pix_y][pix_x] = pix_on;
    end

    cnt_wrap  = (cnt_q == CNT_LAST);
    cnt_d     = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    row_idx_d = cnt_wrap ? row_idx_q + 4'd1 : row_idx_q;

    state_d = state_q;
    latch_d = latch_q;
    case (state_q)
      ST_BLANK: begin
        // Row contents are sampled once, just before the row is lit.
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          latch_d = fb_q[row_idx_q];
        end
      end
      ST_DRIVE: begin
        if (cnt_wrap) state_d = ST_BLANK;
      end
      default: state_d = ST_BLANK;
    endcase

`ifdef BRIGHTNESS_PWM_EN
    pwm_cnt_d = (state_q == ST_DRIVE) ? pwm_cnt_q + 4'd1 : 4'd0;
    col_en    = (state_q == ST_DRIVE) && (pwm_cnt_q < brightness);
`else
    col_en    = (state_q == ST_DRIVE);
`endif

    row_sel_d     = (state_q == ST_DRIVE) ? (ROW_ONE << row_idx_q) : '0;
    col_data_d    = col_en ? latch_q : '0;
    frame_start_d = (cnt_q == '0) && (row_idx_q == 4'd0);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fb_q          <= '0;
      row_idx_q     <= 4'd0;
      cnt_q         <= '0;
      state_q       <= ST_BLANK;
      latch_q       <= '0;
      row_sel_q     <= '0;
      col_data_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      fb_q          <= fb_d;
      row_idx_q     <= row_idx_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      latch_q       <= latch_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef BRIGHTNESS_PWM_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pwm_cnt_q <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`endif

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver with SCAN_DIV=20, BLANK_CYC=4.
// Output position p = registered view of slot-counter cycle p after reset release.
module tb_led_matrix_scan_driver;

  logic        CLK;
  logic        RSTn;
  logic        pix_valid;
  logic [2:0]  pix_x;
  logic [3:0]  pix_y;
  logic        pix_on;
  logic        frame_clr;
  logic [3:0]  brightness;
  logic [15:0] row_sel;
  logic [7:0]  col_data;
  logic        frame_start;

  int n_vec;
  int n_err;
  int k;

  led_matrix_scan_driver #(
    .ROWS(16), .COLS(8), .SCAN_DIV(20), .BLANK_CYC(4)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_on(pix_on),
    .frame_clr(frame_clr),
`ifdef BRIGHTNESS_PWM_EN
    .brightness(brightness),
`endif
    .row_sel(row_sel),
    .col_data(col_data),
    .frame_start(frame_start)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    k++;
    @(negedge CLK);
  endtask

  task automatic run_to(input int p);
    while (k < p + 1) tick();
  endtask

  task automatic wr(input logic [2:0] x, input logic [3:0] y, input logic on, input logic clr);
    pix_x     = x;
    pix_y     = y;
    pix_on    = on;
    pix_valid = 1'b1;
    frame_clr = clr;
    tick();
    pix_valid = 1'b0;
    frame_clr = 1'b0;
  endtask

  // Column gating the PWM build applies at DRIVE cycle (p%20)-4; identity otherwise.
  function automatic logic [7:0] gate(input int p, input logic [7:0] v);
`ifdef BRIGHTNESS_PWM_EN
    return (((p % 20) - 4) < int'(brightness)) ? v : 8'h00;
`else
    if (p < 0) return 8'h00;
    return v;
`endif
  endfunction

  initial begin
    int last_fs;
    int n_pulse;
    int c;
    int r;
    int lit;
    logic [15:0] exp_rs;
    logic [7:0]  exp_col;
    logic [7:0]  row_img;

    n_vec = 0; n_err = 0; k = 0;
    RSTn = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_on = 1'b0;
    frame_clr = 1'b0; brightness = 4'd15;

    repeat (5) @(negedge CLK);
    chk("rst_row_sel", row_sel, 16'h0000);
    chk("rst_col", {8'h00, col_data}, 16'h0000);
    chk("rst_fs", {15'd0, frame_start}, 16'h0000);
    RSTn = 1'b1;
    k = 0;

    run_to(0);
    chk("first_fs", {15'd0, frame_start}, 16'h0001);
    chk("first_rs", row_sel, 16'h0000);
    run_to(1);
    chk("fs_one_cycle", {15'd0, frame_start}, 16'h0000);
    run_to(3);
    chk("blank_rs", row_sel, 16'h0000);
    chk("blank_col", {8'h00, col_data}, 16'h0000);
    run_to(4);
    chk("row0_rs", row_sel, 16'h0001);
    chk("row0_col", {8'h00, col_data}, 16'h0000);

    // Row 0 gets a pixel, then clear+write in one cycle must leave it empty.
    wr(3'd5, 4'd0, 1'b1, 1'b0);
    wr(3'd0, 4'd0, 1'b1, 1'b1);
    wr(3'd3, 4'd2, 1'b1, 1'b0);

    run_to(43);
    chk("row2_blank_rs", row_sel, 16'h0000);
    run_to(44);
    chk("row2_rs", row_sel, 16'h0004);
    chk("row2_col", {8'h00, col_data}, {8'h00, gate(44, 8'h08)});
    run_to(59);
    chk("row2_end_rs", row_sel, 16'h0004);
    chk("row2_end_col", {8'h00, col_data}, {8'h00, gate(59, 8'h08)});
    run_to(60);
    chk("gap_rs", row_sel, 16'h0000);
    chk("gap_col", {8'h00, col_data}, 16'h0000);
    run_to(64);
    chk("row3_rs", row_sel, 16'h0008);
    chk("row3_col", {8'h00, col_data}, 16'h0000);

    // Write to row 5 while it is being driven: no effect until the next slot.
    run_to(105);
    chk("row5_rs", row_sel, 16'h0020);
    chk("row5_col", {8'h00, col_data}, 16'h0000);
    wr(3'd7, 4'd5, 1'b1, 1'b0);
    run_to(119);
    chk("row5_hold_col", {8'h00, col_data}, 16'h0000);
    run_to(304);
    chk("row15_rs", row_sel, 16'h8000);
    run_to(319);
    chk("fs_pre", {15'd0, frame_start}, 16'h0000);
    run_to(320);
    chk("fs_frame1", {15'd0, frame_start}, 16'h0001);
    run_to(324);
    chk("clr_prio_rs", row_sel, 16'h0001);
    chk("clr_prio_col", {8'h00, col_data}, 16'h0000);
    run_to(424);
    chk("row5_next_rs", row_sel, 16'h0020);
    chk("row5_next_col", {8'h00, col_data}, {8'h00, gate(424, 8'h80)});

    // Full scan sweep against a position model.
    last_fs = 320;
    n_pulse = 0;
    for (int p = 425; p <= 700; p++) begin
      run_to(p);
      c = p % 20;
      r = (p / 20) % 16;
      row_img = (r == 2) ? 8'h08 : ((r == 5) ? 8'h80 : 8'h00);
      exp_rs  = (c >= 4) ? (16'h0001 << r) : 16'h0000;
      exp_col = (c >= 4) ? gate(p, row_img) : 8'h00;
      chk("scan_rs", row_sel, exp_rs);
      chk("scan_col", {8'h00, col_data}, {8'h00, exp_col});
      chk("scan_fs", {15'd0, frame_start}, (p % 320 == 0) ? 16'h0001 : 16'h0000);
      if (frame_start) begin
        n_pulse++;
        chk("fs_period", 16'(p - last_fs), 16'd320);
        last_fs = p;
      end
    end
    chk("fs_count", 16'(n_pulse), 16'd1);

    // Asynchronous abort during row 9 DRIVE.
    run_to(830);
    chk("row9_rs", row_sel, 16'h0200);
    RSTn = 1'b0;
    #1;
    chk("async_rs", row_sel, 16'h0000);
    chk("async_col", {8'h00, col_data}, 16'h0000);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    k = 0;
    run_to(0);
    chk("rerst_fs", {15'd0, frame_start}, 16'h0001);
    run_to(4);
    chk("rerst_rs", row_sel, 16'h0001);
    run_to(44);
    chk("rerst_row2_rs", row_sel, 16'h0004);
    chk("rerst_row2_col", {8'h00, col_data}, 16'h0000);

`ifdef BRIGHTNESS_PWM_EN
    brightness = 4'd4;
    wr(3'd3, 4'd2, 1'b1, 1'b0);
    lit = 0;
    for (int p = 360; p <= 379; p++) begin
      run_to(p);
      if (col_data != 8'h00) lit++;
    end
    chk("pwm_duty", 16'(lit), 16'd4);
`else
    lit = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
